sha256_compress_core: RTL and testbench
=======================================

# sha256_compress_core

Self-contained SHA-256 compression engine that accepts one 512-bit padded message block per handshake, expands the message schedule internally, and runs the 64 rounds at a configurable number of rounds per clock. It chains digests across blocks and publishes the 256-bit result with a valid flag. It replaces the purely combinational round/digest update logic by owning the round counter, the A–H working registers, the H0–H7 chaining registers and the schedule window. Upstream is the message padder; downstream is the digest consumer.

## Interface
- `ROUNDS_PER_CYCLE`, default 1: rounds unrolled per clock. Legal values are 1, 2, 4 and 8; any other value is an elaboration error.
- `USE_CSA`, default 1: when 1, the T1 sum (h + Σ1 + Ch + W + K) uses a carry-save tree with a single final adder. When 0, it uses a plain adder chain. Results are bit-identical either way.
- `clk` in 1: single clock. All state changes on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `blk_valid` in 1: `blk_data` and `blk_first` are valid.
- `blk_ready` out 1: the core is idle and can accept a block.
- `blk_data` in 512: padded block. Word 0 is `[511:480]` (big-endian word order).
- `blk_first` in 1: this block starts a new message, so the standard IV is used in place of the chained H.
- `digest` out 256: H0..H7, with H0 at `[255:224]`.
- `digest_valid` out 1: `digest` holds the result of the most recent block.
- `busy` out 1: equal to the inverse of `blk_ready`.

## Operation
- **States**
  - IDLE: `blk_ready` = 1.
  - ROUNDS: round counter `rnd` runs 0..63 in steps of `ROUNDS_PER_CYCLE`.
  - FINAL.
- **Accept**
  - A block is accepted when `blk_valid` and `blk_ready` are both high at a rising edge in IDLE.
  - On accept, `blk_data` is loaded into the 16-word schedule window and the core moves to ROUNDS with `rnd` = 0.
  - If `blk_first` = 1: H0..H7 and A..H are loaded with the IV: 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19.
  - If `blk_first` = 0: A..H are loaded from the current H0..H7, and H0..H7 are left unchanged.
  - `digest_valid` clears on the accept edge.
- **ROUNDS state**
  - Each cycle applies `ROUNDS_PER_CYCLE` chained rounds.
  - One round computes T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + W[t] and T2 = Σ0(a) + Maj(a,b,c).
  - The working registers then update as a←T1+T2, b←a, c←b, d←c, e←d+T1, f←e, g←f, h←g.
- **Rotation constants**
  - Σ0 = ROTR 2/13/22.
  - Σ1 = ROTR 6/11/25.
  - σ0 = ROTR 7, ROTR 18, SHR 3.
  - σ1 = ROTR 17, ROTR 19, SHR 10.
- **Message schedule**
  - W[t] for t < 16 is taken from the window.
  - For t ≥ 16, W[t] = σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16].
  - The window shifts by `ROUNDS_PER_CYCLE` words per cycle. Words beyond t = 63 are don't-care.
- **Constants**: K[0..63] come from an internal constant ROM indexed by `rnd` + i.
- **Arithmetic**: all additions are modulo 2^32 with carries discarded.
- **Round exit**: when the final group of rounds (`rnd` = 64 − `ROUNDS_PER_CYCLE`) is applied, the next state is FINAL.
- **FINAL state**: Hi ← Hi + working register i for all eight registers, `digest_valid` ← 1, next state IDLE.
- **Digest persistence**
  - `digest` always reflects the H registers.
  - After FINAL it holds its value until the next FINAL, a `blk_first` accept (which loads the IV), or reset.
- **Ignored input**: `blk_valid` outside IDLE is ignored, and no input is latched.

## Timing
- **Reset values**
  - State = IDLE, so `blk_ready` = 1 and `busy` = 0.
  - `digest_valid` = 0, `digest` = 0, A..H = 0, `rnd` = 0, window = 0.
- **Latency**
  - For an accept at edge N, the ROUNDS state occupies edges N+1 .. N+64/R, where R = `ROUNDS_PER_CYCLE`.
  - FINAL occurs at edge N+64/R+1, after which `digest_valid` = 1 and `blk_ready` = 1.
  - Examples: edge N+65 for R = 1, edge N+9 for R = 8.
- **Throughput**: back-to-back blocks are accepted one cycle after FINAL, so each block costs 64/R + 2 cycles including the accept cycle.
- **Output holding**: `digest_valid` stays high until the next accept, regardless of `blk_valid`.
- **Non-first block after reset**: a `blk_first` = 0 block arriving with no prior digest chains from H = 0. This is defined behaviour, not an error.
- **Reset mid-operation**
  - Asserting `reset_n` low in any state immediately forces the reset values.
  - The in-flight block is discarded.
  - No `digest_valid` pulse is produced for it.

## Test plan
- **Empty message**: IDLE, R = 1, single block 80000000 followed by fifteen zero words, `blk_first` = 1. Required digest e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855, with `digest_valid` rising exactly 65 edges after accept.
- **"abc" across all widths**: block 61626380, zeros, 00000018, `blk_first` = 1. Run with R = 1, 2, 4, 8 and USE_CSA = 0 and 1. Required digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad in every configuration, with latency 64/R + 1 edges.
- **Two-block chaining**: the 56-byte "abcdbcdecdef…nopq" message, block 1 with `blk_first` = 1 and block 2 with `blk_first` = 0, presented back-to-back. Required digest 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1, with `digest_valid` low between the two results.
- **Valid while busy**: toggle `blk_valid` with random data during ROUNDS. The "abc" digest must be unchanged, and `blk_ready` must be 0 throughout ROUNDS and FINAL.
- **Reset mid-round**: pull `reset_n` low at `rnd` = 30. Every output must return to its reset value at once and `digest_valid` must never pulse. A fresh "abc" block after release must produce the correct digest.
- **New message after completion**: after a completed message, submit "abc" with `blk_first` = 1. The digest must equal the "abc" vector, showing no leakage of the previous H values.

Source files
------------

// File: rtl/sha256_compress_core.sv
// SHA-256 compression engine: accepts one padded 512-bit block per handshake,
// runs the 64 rounds ROUNDS_PER_CYCLE at a time and chains H0..H7 across blocks.
module sha256_compress_core #(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int USE_CSA          = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  input  logic         blk_first,
  output logic [255:0] digest,
  output logic         digest_valid,
  output logic         busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ROUNDS = 2'd1;
  localparam logic [1:0] ST_FINAL  = 2'd2;

  localparam logic [5:0] RND_STEP = 6'(ROUNDS_PER_CYCLE);
  localparam logic [5:0] RND_LAST = 6'(64 - ROUNDS_PER_CYCLE);

  generate
    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
          ROUNDS_PER_CYCLE == 4 || ROUNDS_PER_CYCLE == 8)) begin : g_bad_rpc
      $error("sha256_compress_core: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
    end
  endgenerate

  localparam logic [31:0] K_TABLE [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, y, z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, y, z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  // Majority is exactly the carry of a full adder, so the 3:2 compressors reuse maj().
  function automatic logic [31:0] t1_sum(input logic [31:0] h, s1, c, k, w);
    logic [31:0] s_a, c_a, s_b, c_b, s_c, c_c;
    s_a = h ^ s1 ^ c;
    c_a = maj(h, s1, c) << 1;
    s_b = s_a ^ c_a ^ k;
    c_b = maj(s_a, c_a, k) << 1;
    s_c = s_b ^ c_b ^ w;
    c_c = maj(s_b, c_b, w) << 1;
    if (USE_CSA != 0) return s_c + c_c;
    return h + s1 + c + k + w;
  endfunction

  logic [1:0]  state_q, state_d;
  logic [5:0]  rnd_q, rnd_d;
  logic        dv_q, dv_d;
  logic [31:0] wv_q [0:7];
  logic [31:0] wv_d [0:7];
  logic [31:0] h_q [0:7];
  logic [31:0] h_d [0:7];
  logic [31:0] w_q [0:15];
  logic [31:0] w_d [0:15];

  always_comb begin : next_state
    logic [31:0] ext [0:15+ROUNDS_PER_CYCLE];
    logic [31:0] va, vb, vc, vd, ve, vf, vg, vh, t1, t2;

    state_d = state_q;
    rnd_d   = rnd_q;
    dv_d    = dv_q;
    wv_d    = wv_q;
    h_d     = h_q;
    w_d     = w_q;

    // ext[j] holds W[rnd + j]; the top R entries are the newly expanded words.
    for (int j = 0; j < 16; j++) ext[j] = w_q[j];
    for (int k = 0; k < ROUNDS_PER_CYCLE; k++) begin
      ext[16+k] = small_sigma1(ext[14+k]) + ext[9+k] + small_sigma0(ext[1+k]) + ext[k];
    end

    va = wv_q[0]; vb = wv_q[1]; vc = wv_q[2]; vd = wv_q[3];
    ve = wv_q[4]; vf = wv_q[5]; vg = wv_q[6]; vh = wv_q[7];
    t1 = '0;
    t2 = '0;
    for (int i = 0; i < ROUNDS_PER_CYCLE; i++) begin
      t1 = t1_sum(vh, big_sigma1(ve), ch(ve, vf, vg), K_TABLE[rnd_q + 6'(i)], ext[i]);
      t2 = big_sigma0(va) + maj(va, vb, vc);
      vh = vg;
      vg = vf;
      vf = ve;
      ve = vd + t1;
      vd = vc;
      vc = vb;
      vb = va;
      va = t1 + t2;
    end

    case (state_q)
      ST_IDLE: begin
        if (blk_valid) begin
          for (int j = 0; j < 16; j++) w_d[j] = blk_data[511-32*j -: 32];
          rnd_d   = '0;
          dv_d    = 1'b0;
          state_d = ST_ROUNDS;
          for (int i = 0; i < 8; i++) begin
            if (blk_first) begin
              h_d[i]  = IV[i];
              wv_d[i] = IV[i];
            end else begin
              wv_d[i] = h_q[i];
            end
          end
        end
      end
      ST_ROUNDS: begin
        wv_d[0] = va; wv_d[1] = vb; wv_d[2] = vc; wv_d[3] = vd;
        wv_d[4] = ve; wv_d[5] = vf; wv_d[6] = vg; wv_d[7] = vh;
        for (int j = 0; j < 16; j++) w_d[j] = ext[j+ROUNDS_PER_CYCLE];
        rnd_d = rnd_q + RND_STEP;
        if (rnd_q == RND_LAST) state_d = ST_FINAL;
      end
      ST_FINAL: begin
        for (int i = 0; i < 8; i++) h_d[i] = h_q[i] + wv_q[i];
        dv_d    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      rnd_q   <= '0;
      dv_q    <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        wv_q[i] <= '0;
        h_q[i]  <= '0;
      end
      for (int j = 0; j < 16; j++) w_q[j] <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      dv_q    <= dv_d;
      for (int i = 0; i < 8; i++) begin
        wv_q[i] <= wv_d[i];
        h_q[i]  <= h_d[i];
      end
      for (int j = 0; j < 16; j++) w_q[j] <= w_d[j];
    end
  end

  assign blk_ready    = (state_q == ST_IDLE);
  assign busy         = ~blk_ready;
  assign digest_valid = dv_q;
  assign digest       = {h_q[0], h_q[1], h_q[2], h_q[3], h_q[4], h_q[5], h_q[6], h_q[7]};

endmodule

// File: tb/tb_sha256_compress_core.sv
// Self-checking bench for sha256_compress_core: known-answer vectors through a
// scoreboard on an R=1 instance, plus five extra instances covering other widths.
module tb_sha256_compress_core;

  localparam int NX = 5;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         blk_valid;
  logic         blk_first;
  logic [511:0] blk_data;
  logic         blk_ready;
  logic         busy;
  logic         digest_valid;
  logic [255:0] digest;

  logic [NX-1:0] x_ready;
  logic [NX-1:0] x_busy;
  logic [NX-1:0] x_dv;
  logic [255:0]  x_digest [NX];

  always #5 clk = ~clk;

  sha256_compress_core #(.ROUNDS_PER_CYCLE(1), .USE_CSA(1)) dut (
    .clk(clk), .reset_n(reset_n), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .blk_data(blk_data), .blk_first(blk_first), .digest(digest),
    .digest_valid(digest_valid), .busy(busy)
  );

  function automatic int xr(input int g);
    case (g)
      0:       return 2;
      1:       return 4;
      2:       return 8;
      3:       return 1;
      default: return 8;
    endcase
  endfunction

  function automatic int xc(input int g);
    case (g)
      0:       return 0;
      1:       return 1;
      2:       return 0;
      3:       return 0;
      default: return 1;
    endcase
  endfunction

  // Extra instances share every input with the main DUT.
  generate
    for (genvar g = 0; g < NX; g++) begin : g_x
      sha256_compress_core #(.ROUNDS_PER_CYCLE(xr(g)), .USE_CSA(xc(g))) u_core (
        .clk(clk), .reset_n(reset_n), .blk_valid(blk_valid), .blk_ready(x_ready[g]),
        .blk_data(blk_data), .blk_first(blk_first), .digest(x_digest[g]),
        .digest_valid(x_dv[g]), .busy(x_busy[g])
      );
    end
  endgenerate

  typedef struct packed {
    logic [511:0] blk;
    logic         first;
    logic [255:0] exp;
    logic         chk;
  } vec_t;

  typedef struct packed {
    logic [255:0] exp;
    logic         chk;
    int           acc;
    int           id;
  } sb_t;

  vec_t  vecs [5];
  string vec_names [5];
  sb_t   sb_q [$];
  int    checks = 0;
  int    passes = 0;
  int    cyc = 0;
  logic  prev_dv = 1'b0;

  localparam logic [255:0] ABC_DIGEST =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
  endtask

  // Scoreboard consumer: each rising digest_valid retires the oldest accepted block.
  always @(negedge clk) begin
    sb_t e;
    if (digest_valid && !prev_dv) begin
      if (sb_q.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected_digest_valid: digest_valid=1 with no block outstanding, required 0");
      end else begin
        e = sb_q.pop_front();
        checkOutput($sformatf("latency_%s", vec_names[e.id]), 256'(cyc - e.acc), 256'(65));
        if (e.chk) checkOutput($sformatf("digest_%s", vec_names[e.id]), digest, e.exp);
      end
    end
    prev_dv = digest_valid;
  end

  task automatic applyStimulus(input vec_t v, input int id, input bit track);
    int  waited = 0;
    sb_t e;
    @(negedge clk);
    while (!blk_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!blk_ready) begin
      checks++;
      $display("[TB] FAIL ready_timeout_%s: blk_ready=%0b, required 1", vec_names[id], blk_ready);
      return;
    end
    blk_data  = v.blk;
    blk_first = v.first;
    blk_valid = 1'b1;
    if (track) begin
      e.exp = v.exp;
      e.chk = v.chk;
      e.acc = cyc + 1;
      e.id  = id;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1 blk_valid = 1'b0;
  endtask

  task automatic drainScoreboard();
    int waited = 0;
    while (sb_q.size() != 0 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      $display("[TB] FAIL drain_timeout: %0d blocks outstanding, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_blk_ready"}, 256'(blk_ready), 256'(1));
    checkOutput({tag, "_busy"}, 256'(busy), 256'(0));
    checkOutput({tag, "_digest_valid"}, 256'(digest_valid), 256'(0));
    checkOutput({tag, "_digest"}, digest, 256'(0));
  endtask

  initial begin
    int   bad;
    int   pulses;
    int   acc;
    int   lat [NX];
    logic [255:0] got [NX];

    blk_valid = 1'b0;
    blk_first = 1'b0;
    blk_data  = '0;
    reset_n   = 1'b0;

    vecs[0] = '{blk: {32'h80000000, 480'h0}, first: 1'b1, chk: 1'b1,
                exp: 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855};
    vecs[1] = '{blk: {32'h61626380, 448'h0, 32'h00000018}, first: 1'b1, chk: 1'b1, exp: ABC_DIGEST};
    vecs[2] = '{blk: {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000},
                first: 1'b1, chk: 1'b0, exp: 256'h0};
    vecs[3] = '{blk: {480'h0, 32'h000001c0}, first: 1'b0, chk: 1'b1,
                exp: 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1};
    vecs[4] = vecs[1];
    vec_names[0] = "empty";
    vec_names[1] = "abc";
    vec_names[2] = "two_block_1";
    vec_names[3] = "two_block_2";
    vec_names[4] = "abc_new_msg";

    repeat (3) @(posedge clk);
    #1 checkResetOutputs("reset_held");
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk) checkResetOutputs("reset_released");

    // Known-answer vectors; the two-block pair goes in back-to-back.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i], i, 1'b1);
      checkOutput($sformatf("dv_clears_on_accept_%s", vec_names[i]), 256'(digest_valid), 256'(0));
    end
    drainScoreboard();
    repeat (5) @(negedge clk);
    checkOutput("digest_holds_idle", digest, ABC_DIGEST);
    checkOutput("dv_holds_idle", 256'(digest_valid), 256'(1));

    // Random blk_valid traffic while the core is busy must be ignored.
    applyStimulus(vecs[1], 1, 1'b1);
    bad = 0;
    for (int k = 0; k < 65; k++) begin
      @(negedge clk);
      if (blk_ready !== 1'b0 || busy !== 1'b1) bad++;
      blk_valid = 1'($urandom_range(0, 1));
      blk_first = 1'($urandom_range(0, 1));
      blk_data  = {16{$urandom()}};
    end
    @(negedge clk) blk_valid = 1'b0;
    checkOutput("ready_low_while_busy", 256'(bad), 256'(0));
    drainScoreboard();

    // Abort a block at round 30 and confirm it leaves no trace.
    applyStimulus(vecs[1], 1, 1'b0);
    repeat (30) @(posedge clk);
    #1 reset_n = 1'b0;
    #1 checkResetOutputs("reset_mid_round");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (digest_valid !== 1'b0) pulses++;
    end
    checkOutput("no_dv_after_abort", 256'(pulses), 256'(0));
    applyStimulus(vecs[1], 1, 1'b1);
    drainScoreboard();

    // Same "abc" block on every width/adder configuration at once.
    @(negedge clk) reset_n = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk);
    checkOutput("x_ready_busy_after_reset", 256'({x_ready, x_busy}), 256'({5'b11111, 5'b00000}));
    applyStimulus(vecs[1], 1, 1'b1);
    acc = cyc;
    for (int g = 0; g < NX; g++) begin
      lat[g] = -1;
      got[g] = '0;
    end
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      for (int g = 0; g < NX; g++) begin
        if (x_dv[g] && lat[g] < 0) begin
          lat[g] = cyc - acc;
          got[g] = x_digest[g];
        end
      end
    end
    for (int g = 0; g < NX; g++) begin
      checkOutput($sformatf("latency_R%0d_CSA%0d", xr(g), xc(g)), 256'(lat[g]), 256'(64 / xr(g) + 1));
      checkOutput($sformatf("digest_R%0d_CSA%0d", xr(g), xc(g)), got[g], ABC_DIGEST);
    end
    drainScoreboard();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
